// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// The master modport is the initiator side. The slave modport is the responder side.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  logic [7:0]        rsp_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_count
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding byte memory responder with a valid/ready request and response handshake.
// Defining MEM_WAIT_EN inserts a one-cycle WAIT state before every response.
module mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_responder_if.slave      bus
);

`ifdef MEM_WAIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        ready_en;
  logic        accept;
  logic        rsp_done;
  logic [7:0]  rdata_q;
  logic [7:0]  count_q;
  logic [7:0]  mem [2**ADDR_W];

`ifdef MEM_WAIT_EN
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
`endif

  // ready_en holds req_ready low while reset is asserted.
  // It also holds req_ready low until the first edge after reset is released.
  assign bus.req_ready = (state == IDLE) && ready_en;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_count = count_q;

  assign accept   = bus.req_valid && bus.req_ready;
  assign rsp_done = (state == RESP) && bus.rsp_ready;

  // NOTE: use non-blocking (<=) for every flop, so all registers update together at the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // NOTE: assign state_nxt a default first, so every path drives it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
`ifdef MEM_WAIT_EN
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
`else
      IDLE:    if (accept) state_nxt = RESP;
`endif
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset, so its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we) mem[bus.req_addr] <= bus.req_wdata;
  end

`ifdef MEM_WAIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else if (accept) begin
      we_q   <= bus.req_we;
      addr_q <= bus.req_addr;
    end
  end

  // A write echoes its data at the accept edge. A read samples the memory at the WAIT exit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 8'h00;
    end else if (accept) begin
      if (bus.req_we) rdata_q <= bus.req_wdata;
    end else if (state == WAIT && !we_q) begin
      rdata_q <= mem[addr_q];
    end
  end
`else
  // The read uses the memory value before this edge. A write to the same address lands at this edge too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 8'h00;
    end else if (accept) begin
      rdata_q <= bus.req_we ? bus.req_wdata : mem[bus.req_addr];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'h00;
    end else if (rsp_done) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule
